// File: rtl/tiny_io_pkg.sv
// Shared constants for tiny_io_port: default word width, FIFO depth and error-counter sizing.
// The error counter only exists when TINY_IO_ERRCNT_EN is defined.
package tiny_io_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned ERR_W         = 8;

    typedef logic [ERR_W-1:0] err_cnt_t;

    localparam err_cnt_t ERR_MAX = ERR_W'(255);

    // Saturating add of 0..2 events onto the error counter.
    function automatic err_cnt_t err_add(input err_cnt_t cnt, input logic [1:0] inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + (ERR_W + 1)'(inc);
        return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/tiny_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is read combinationally.
// Push into a full FIFO is taken only when a pop happens on the same edge.
module tiny_fifo
    import tiny_io_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointers wrap modulo 2*DEPTH; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is not reset: contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/tiny_io_port.sv
// CPU I/O port: input FIFO from an Rx handshake, output FIFO to a Tx handshake.
// Define TINY_IO_ERRCNT_EN to add the saturating ErrCnt underflow/overflow counter.
module tiny_io_port
    import tiny_io_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Ph0,
    input  logic             Reset,
    output logic [WIDTH-1:0] InData,
    output logic             InRdy,
    input  logic             InStrobe,
    input  logic [WIDTH-1:0] OutData,
    input  logic             OutStrobe,
    input  logic [WIDTH-1:0] RxData,
    input  logic             RxValid,
    output logic             RxReady,
    output logic [WIDTH-1:0] TxData,
    output logic             TxValid,
    input  logic             TxReady
`ifdef TINY_IO_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] ErrCnt
`endif
);

    logic in_full;
    logic in_empty;
    logic in_push;
    logic in_pop;
    logic out_full;
    logic out_empty;
    logic out_push;
    logic out_pop;

    // Input side: producer may push whenever there is room, CPU pops when data is there.
    assign RxReady = ~in_full;
    assign InRdy   = ~in_empty;
    assign in_push = RxValid & ~in_full;
    assign in_pop  = InStrobe & ~in_empty;

    // Output side: a full FIFO still accepts a word when the consumer drains one on the same edge.
    assign TxValid  = ~out_empty;
    assign out_pop  = TxReady & ~out_empty;
    assign out_push = OutStrobe & (~out_full | out_pop);

    tiny_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_in_fifo (
        .clk   (Ph0),
        .rst   (Reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (RxData),
        .full  (in_full),
        .empty (in_empty),
        .head  (InData)
    );

    tiny_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_out_fifo (
        .clk   (Ph0),
        .rst   (Reset),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (OutData),
        .full  (out_full),
        .empty (out_empty),
        .head  (TxData)
    );

`ifdef TINY_IO_ERRCNT_EN
    logic       underflow;
    logic       overflow;
    logic [1:0] err_inc;

    assign underflow = InStrobe & in_empty;
    assign overflow  = OutStrobe & ~out_push;
    assign err_inc   = {1'b0, underflow} + {1'b0, overflow};

    // Both error kinds on one edge count twice; the counter sticks at its maximum.
    always_ff @(posedge Ph0 or posedge Reset) begin
        if (Reset) begin
            ErrCnt <= '0;
        end else if (err_inc != 2'd0) begin
            ErrCnt <= err_add(ErrCnt, err_inc);
        end
    end
`endif

endmodule

// File: tb/tb_tiny_io_port.sv
// Self-checking bench for tiny_io_port: directed scenarios plus random traffic vs a queue model.
// ErrCnt checks are compiled in only when TINY_IO_ERRCNT_EN is defined.
module tb_tiny_io_port;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic             Ph0 = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] InData;
    logic             InRdy;
    logic             InStrobe;
    logic [WIDTH-1:0] OutData;
    logic             OutStrobe;
    logic [WIDTH-1:0] RxData;
    logic             RxValid;
    logic             RxReady;
    logic [WIDTH-1:0] TxData;
    logic             TxValid;
    logic             TxReady;
`ifdef TINY_IO_ERRCNT_EN
    logic [7:0]       ErrCnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] in_q[$];
    logic [WIDTH-1:0] out_q[$];
    int               err_m;

    tiny_io_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .Ph0       (Ph0),
        .Reset     (Reset),
        .InData    (InData),
        .InRdy     (InRdy),
        .InStrobe  (InStrobe),
        .OutData   (OutData),
        .OutStrobe (OutStrobe),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .RxReady   (RxReady),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady)
`ifdef TINY_IO_ERRCNT_EN
        ,
        .ErrCnt    (ErrCnt)
`endif
    );

    always #5 Ph0 = ~Ph0;

    task automatic idle();
        InStrobe  = 1'b0;
        OutStrobe = 1'b0;
        RxValid   = 1'b0;
        TxReady   = 1'b0;
        RxData    = '0;
        OutData   = '0;
    endtask

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        err_m = 0;
    endtask

    // Advance one rising edge and apply the same rules to the queue model.
    task automatic step();
        bit in_room, in_has, out_pop_m, out_room;
        int n_err;
        @(posedge Ph0);
        if (Reset) begin
            model_clear();
        end else begin
            n_err     = 0;
            in_room   = in_q.size() < int'(DEPTH);
            in_has    = in_q.size() > 0;
            out_pop_m = TxReady && out_q.size() > 0;
            out_room  = (out_q.size() < int'(DEPTH)) || out_pop_m;
            if (InStrobe && !in_has) n_err++;
            if (InStrobe && in_has) void'(in_q.pop_front());
            if (RxValid && in_room) in_q.push_back(RxData);
            if (out_pop_m) void'(out_q.pop_front());
            if (OutStrobe && out_room) out_q.push_back(OutData);
            if (OutStrobe && !out_room) n_err++;
            err_m = (err_m + n_err > 255) ? 255 : err_m + n_err;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        model_clear();
        @(posedge Ph0);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        model_clear();
        #1;
        vectors++; if (InRdy !== 1'b0) begin miscompares++; $display("FAIL reset_inrdy: got %b want 0", InRdy); end
        vectors++; if (TxValid !== 1'b0) begin miscompares++; $display("FAIL reset_txvalid: got %b want 0", TxValid); end
        vectors++; if (RxReady !== 1'b1) begin miscompares++; $display("FAIL reset_rxready: got %b want 1", RxReady); end
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd0) begin miscompares++; $display("FAIL reset_errcnt: got %0d want 0", ErrCnt); end
`endif
        @(posedge Ph0);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_in_order();
        logic [WIDTH-1:0] exp_w [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            RxValid = 1'b1;
            RxData  = exp_w[i];
            step();
            vectors++; if (InRdy !== 1'b1) begin miscompares++; $display("FAIL in_order_latency[%0d]: InRdy %b want 1", i, InRdy); end
        end
        RxValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (InData !== exp_w[i]) begin miscompares++; $display("FAIL in_order_data[%0d]: got %h want %h", i, InData, exp_w[i]); end
            InStrobe = 1'b1;
            step();
        end
        InStrobe = 1'b0;
        vectors++; if (InRdy !== 1'b0) begin miscompares++; $display("FAIL in_order_drained: InRdy %b want 0", InRdy); end
    endtask

    task automatic test_in_full();
        logic [WIDTH-1:0] w;
        do_reset();
        RxValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            RxData = WIDTH'(32'hC0 + i);
            step();
            if (i == 3) begin
                vectors++; if (RxReady !== 1'b0) begin miscompares++; $display("FAIL in_full_rxready: got %b want 0", RxReady); end
            end
        end
        vectors++; if (InData !== 32'hC0) begin miscompares++; $display("FAIL in_full_head: got %h want c0", InData); end
        InStrobe = 1'b1;
        step();
        InStrobe = 1'b0;
        vectors++; if (RxReady !== 1'b1) begin miscompares++; $display("FAIL in_full_room: RxReady %b want 1", RxReady); end
        step();
        vectors++; if (RxReady !== 1'b0) begin miscompares++; $display("FAIL in_full_refill: RxReady %b want 0", RxReady); end
        RxValid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            w = WIDTH'(32'hC0 + i);
            vectors++; if (InData !== w) begin miscompares++; $display("FAIL in_full_order[%0d]: got %h want %h", i, InData, w); end
            InStrobe = 1'b1;
            step();
        end
        InStrobe = 1'b0;
        vectors++; if (InRdy !== 1'b0) begin miscompares++; $display("FAIL in_full_empty: InRdy %b want 0", InRdy); end
    endtask

    task automatic test_out_overflow();
        logic [WIDTH-1:0] w;
        do_reset();
        OutStrobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            OutData = WIDTH'(32'hA0 + i);
            step();
            if (i == 0) begin
                vectors++; if (TxValid !== 1'b1) begin miscompares++; $display("FAIL out_latency: TxValid %b want 1", TxValid); end
            end
        end
        OutStrobe = 1'b0;
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd1) begin miscompares++; $display("FAIL out_overflow_err: got %0d want 1", ErrCnt); end
`endif
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'(32'hA0 + i);
            vectors++; if (TxData !== w || TxValid !== 1'b1) begin miscompares++; $display("FAIL out_order[%0d]: got %h/%b want %h/1", i, TxData, TxValid, w); end
            step();
        end
        TxReady = 1'b0;
        vectors++; if (TxValid !== 1'b0) begin miscompares++; $display("FAIL out_dropped: TxValid %b want 0", TxValid); end
    endtask

    task automatic test_out_full_simul();
        logic [WIDTH-1:0] w;
        do_reset();
        OutStrobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            OutData = WIDTH'(32'hB0 + i);
            step();
        end
        OutData = 32'hB4;
        TxReady = 1'b1;
        step();
        OutStrobe = 1'b0;
        TxReady   = 1'b0;
        vectors++; if (TxData !== 32'hB1) begin miscompares++; $display("FAIL simul_head: got %h want b1", TxData); end
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd0) begin miscompares++; $display("FAIL simul_err: got %0d want 0", ErrCnt); end
`endif
        TxReady = 1'b1;
        for (int i = 1; i < 5; i++) begin
            w = WIDTH'(32'hB0 + i);
            vectors++; if (TxData !== w || TxValid !== 1'b1) begin miscompares++; $display("FAIL simul_order[%0d]: got %h/%b want %h/1", i, TxData, TxValid, w); end
            step();
        end
        TxReady = 1'b0;
        vectors++; if (TxValid !== 1'b0) begin miscompares++; $display("FAIL simul_count: TxValid %b want 0", TxValid); end
    endtask

    task automatic test_underflow_sat();
        do_reset();
        InStrobe = 1'b1;
        step();
        InStrobe = 1'b0;
        vectors++; if (InRdy !== 1'b0 || RxReady !== 1'b1) begin miscompares++; $display("FAIL underflow_state: InRdy %b RxReady %b want 0 1", InRdy, RxReady); end
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd1) begin miscompares++; $display("FAIL underflow_err: got %0d want 1", ErrCnt); end
`endif
        InStrobe = 1'b1;
        repeat (300) step();
        InStrobe = 1'b0;
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd255) begin miscompares++; $display("FAIL err_saturate: got %0d want 255", ErrCnt); end
`endif
        // Underflow and overflow on the same edge.
        do_reset();
        OutStrobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            OutData = WIDTH'(32'hD0 + i);
            step();
        end
        OutData  = 32'hDF;
        InStrobe = 1'b1;
        step();
        idle();
        vectors++; if (TxData !== 32'hD0 || InRdy !== 1'b0) begin miscompares++; $display("FAIL double_state: TxData %h InRdy %b want d0 0", TxData, InRdy); end
`ifdef TINY_IO_ERRCNT_EN
        vectors++; if (ErrCnt !== 8'd2) begin miscompares++; $display("FAIL double_err: got %0d want 2", ErrCnt); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        RxValid   = 1'b1;
        OutStrobe = 1'b1;
        for (int i = 0; i < 2; i++) begin
            RxData  = WIDTH'(32'hE0 + i);
            OutData = WIDTH'(32'hF0 + i);
            step();
        end
        idle();
        vectors++; if (InRdy !== 1'b1 || TxValid !== 1'b1) begin miscompares++; $display("FAIL areset_pre: InRdy %b TxValid %b want 1 1", InRdy, TxValid); end
        #2;
        Reset = 1'b1;
        model_clear();
        #1;
        vectors++; if (InRdy !== 1'b0) begin miscompares++; $display("FAIL areset_inrdy: got %b want 0", InRdy); end
        vectors++; if (TxValid !== 1'b0) begin miscompares++; $display("FAIL areset_txvalid: got %b want 0", TxValid); end
        vectors++; if (RxReady !== 1'b1) begin miscompares++; $display("FAIL areset_rxready: got %b want 1", RxReady); end
        // Traffic offered while reset is held must not be captured.
        RxValid   = 1'b1;
        OutStrobe = 1'b1;
        RxData    = 32'h5A;
        OutData   = 32'hA5;
        step();
        idle();
        Reset = 1'b0;
        #1;
        vectors++; if (InRdy !== 1'b0 || TxValid !== 1'b0) begin miscompares++; $display("FAIL areset_hold: InRdy %b TxValid %b want 0 0", InRdy, TxValid); end
    endtask

    task automatic test_random();
        int p_rx, p_in, p_out, p_tx;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) begin
                p_rx  = int'($urandom_range(10, 90));
                p_in  = int'($urandom_range(10, 90));
                p_out = int'($urandom_range(10, 90));
                p_tx  = int'($urandom_range(10, 90));
            end
            RxValid   = int'($urandom_range(0, 99)) < p_rx;
            InStrobe  = int'($urandom_range(0, 99)) < p_in;
            OutStrobe = int'($urandom_range(0, 99)) < p_out;
            TxReady   = int'($urandom_range(0, 99)) < p_tx;
            RxData    = $urandom;
            OutData   = $urandom;
            step();
            vectors++; if (InRdy !== (in_q.size() != 0)) begin miscompares++; $display("FAIL rand_inrdy @%0d: got %b want %b", n, InRdy, in_q.size() != 0); end
            vectors++; if (RxReady !== (in_q.size() < int'(DEPTH))) begin miscompares++; $display("FAIL rand_rxready @%0d: got %b want %b", n, RxReady, in_q.size() < int'(DEPTH)); end
            vectors++; if (TxValid !== (out_q.size() != 0)) begin miscompares++; $display("FAIL rand_txvalid @%0d: got %b want %b", n, TxValid, out_q.size() != 0); end
            if (in_q.size() != 0) begin
                vectors++; if (InData !== in_q[0]) begin miscompares++; $display("FAIL rand_indata @%0d: got %h want %h", n, InData, in_q[0]); end
            end
            if (out_q.size() != 0) begin
                vectors++; if (TxData !== out_q[0]) begin miscompares++; $display("FAIL rand_txdata @%0d: got %h want %h", n, TxData, out_q[0]); end
            end
`ifdef TINY_IO_ERRCNT_EN
            vectors++; if (int'(ErrCnt) !== err_m) begin miscompares++; $display("FAIL rand_errcnt @%0d: got %0d want %0d", n, ErrCnt, err_m); end
`endif
        end
        idle();
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        test_reset();
        test_in_order();
        test_in_full();
        test_out_overflow();
        test_out_full_simul();
        test_underflow_sat();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
